// File: rtl/stereo_rd_pkg.sv
// Shared types and constants for the stereo FIFO read-side controller.
package stereo_rd_pkg;

  localparam int CNT_WIDTH          = 16;
  localparam int DEFAULT_DATA_WIDTH = 24;

  // DRAIN flushes an in-flight or pending frame after enable falls.
  typedef enum logic [1:0] {
    IDLE,
    PREFILL,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/rd_lat_tracker.sv
// Delays the pop strobe by RD_LAT cycles to time the data capture, and
// reports whether any pop is still waiting for its read data.
module rd_lat_tracker #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic pop,
  output logic capture,
  output logic inflight
);

  logic [RD_LAT-1:0] pipe_reg;

  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_reg[gi] <= 1'b0;
        end else if (gi == 0) begin
          pipe_reg[gi] <= pop;
        end else begin
          pipe_reg[gi] <= pipe_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  // Data is valid in the last stage's cycle; capture on the edge that ends it.
  assign capture  = pipe_reg[RD_LAT-1];
  assign inflight = |pipe_reg;

endmodule

// File: rtl/stereo_fifo_rd_ctrl.sv
// Lockstep L/R FIFO read sequencer with prefill, valid/ready frame output and
// underrun recovery. Define STEREO_FIFO_RD_CTRL_UNDERRUN_CNT_EN for underrun_cnt.
module stereo_fifo_rd_ctrl
  import stereo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  l_empty,
  input  logic                  l_almost_empty,
  output logic                  l_rd_en,
  input  logic [DATA_WIDTH-1:0] l_rd_data,
  input  logic                  r_empty,
  input  logic                  r_almost_empty,
  output logic                  r_rd_en,
  input  logic [DATA_WIDTH-1:0] r_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_left,
  output logic [DATA_WIDTH-1:0] out_right,
  output logic                  underrun,
`ifdef STEREO_FIFO_RD_CTRL_UNDERRUN_CNT_EN
  output logic [CNT_WIDTH-1:0]  underrun_cnt,
`endif
  output logic                  streaming
);

  state_t                state_reg;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] out_left_reg;
  logic [DATA_WIDTH-1:0] out_right_reg;
  logic                  underrun_reg;
  logic                  pop;
  logic                  capture;
  logic                  inflight;
  logic                  underrun_det;
  logic                  drain_done;

  // A single pop strobe feeds both FIFOs so the channels cannot skew.
  assign pop = (state_reg == RUN) && enable && !inflight && !l_empty && !r_empty
               && (!out_valid_reg || out_ready);

  assign underrun_det = (state_reg == RUN) && enable && out_ready && !out_valid_reg
                        && !inflight && (l_empty || r_empty);

  assign drain_done = !inflight && (!out_valid_reg || out_ready);

  rd_lat_tracker #(
    .RD_LAT (RD_LAT)
  ) u_lat (
    .clk      (clk),
    .rst      (rst),
    .pop      (pop),
    .capture  (capture),
    .inflight (inflight)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      out_left_reg  <= '0;
      out_right_reg <= '0;
      underrun_reg  <= 1'b0;
    end else begin
      underrun_reg <= underrun_det;

      if (capture) begin
        out_valid_reg <= 1'b1;
        out_left_reg  <= l_rd_data;
        out_right_reg <= r_rd_data;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE:    if (enable) state_reg <= PREFILL;
        PREFILL: begin
          if (!enable)                             state_reg <= IDLE;
          else if (!l_almost_empty && !r_almost_empty) state_reg <= RUN;
        end
        RUN: begin
          if (!enable)           state_reg <= DRAIN;
          else if (underrun_det) state_reg <= PREFILL;
        end
        DRAIN:   if (drain_done) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef STEREO_FIFO_RD_CTRL_UNDERRUN_CNT_EN
  logic                 enable_d_reg;
  logic [CNT_WIDTH-1:0] underrun_cnt_reg;

  // A fresh enable starts a new counting session; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_d_reg     <= 1'b0;
      underrun_cnt_reg <= '0;
    end else begin
      enable_d_reg <= enable;
      if (enable && !enable_d_reg) begin
        underrun_cnt_reg <= '0;
      end else if (underrun_det && (underrun_cnt_reg != '1)) begin
        underrun_cnt_reg <= underrun_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign underrun_cnt = underrun_cnt_reg;
`endif

  assign l_rd_en   = pop;
  assign r_rd_en   = pop;
  assign out_valid = out_valid_reg;
  assign out_left  = out_left_reg;
  assign out_right = out_right_reg;
  assign underrun  = underrun_reg;
  assign streaming = (state_reg == RUN);

endmodule

// File: tb/tb_stereo_fifo_rd_ctrl.sv
// Scoreboard bench for stereo_fifo_rd_ctrl: queue-based FIFO models feed the
// DUT, written pairs are the expected frame stream, a monitor checks output.
module tb_stereo_fifo_rd_ctrl;
  import stereo_rd_pkg::*;

  localparam int DW       = 24;
  localparam int RD_LAT   = 1;
  localparam int AE_LEVEL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          l_empty, l_almost_empty, l_rd_en;
  logic          r_empty, r_almost_empty, r_rd_en;
  logic [DW-1:0] l_rd_data, r_rd_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_left, out_right;
  logic          underrun, streaming;
`ifdef STEREO_FIFO_RD_CTRL_UNDERRUN_CNT_EN
  logic [CNT_WIDTH-1:0] underrun_cnt;
`endif

  always #5 clk = ~clk;

  stereo_fifo_rd_ctrl #(
    .DATA_WIDTH (DW),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .l_empty        (l_empty),
    .l_almost_empty (l_almost_empty),
    .l_rd_en        (l_rd_en),
    .l_rd_data      (l_rd_data),
    .r_empty        (r_empty),
    .r_almost_empty (r_almost_empty),
    .r_rd_en        (r_rd_en),
    .r_rd_data      (r_rd_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_left       (out_left),
    .out_right      (out_right),
    .underrun       (underrun),
`ifdef STEREO_FIFO_RD_CTRL_UNDERRUN_CNT_EN
    .underrun_cnt   (underrun_cnt),
`endif
    .streaming      (streaming)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // FIFO models: data pushed by stimulus lands on the next clock edge.
  logic [DW-1:0] lq[$], rq[$], lwr[$], rwr[$];
  logic [DW-1:0] l_pipe[RD_LAT], r_pipe[RD_LAT];
  int            l_cnt, r_cnt;

  assign l_empty        = (l_cnt == 0);
  assign r_empty        = (r_cnt == 0);
  assign l_almost_empty = (l_cnt <= AE_LEVEL);
  assign r_almost_empty = (r_cnt <= AE_LEVEL);
  assign l_rd_data      = l_pipe[RD_LAT-1];
  assign r_rd_data      = r_pipe[RD_LAT-1];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lq.delete(); rq.delete(); lwr.delete(); rwr.delete();
      l_cnt <= 0;
      r_cnt <= 0;
      for (int i = 0; i < RD_LAT; i++) begin
        l_pipe[i] <= '0;
        r_pipe[i] <= '0;
      end
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        l_pipe[i] <= l_pipe[i-1];
        r_pipe[i] <= r_pipe[i-1];
      end
      if (l_rd_en && lq.size() > 0) l_pipe[0] <= lq.pop_front();
      if (r_rd_en && rq.size() > 0) r_pipe[0] <= rq.pop_front();
      while (lwr.size() > 0) lq.push_back(lwr.pop_front());
      while (rwr.size() > 0) rq.push_back(rwr.pop_front());
      l_cnt <= lq.size();
      r_cnt <= rq.size();
    end
  end

  // Scoreboard: the n-th frame must carry the n-th written left and right samples.
  logic [DW-1:0] exp_l[$], exp_r[$];
  int            frames_rx     = 0;
  int            pop_count     = 0;
  int            underrun_seen = 0;
  logic          hold_prev     = 1'b0;
  logic          und_prev      = 1'b0;
  logic [DW-1:0] hold_l, hold_r;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
      und_prev  = 1'b0;
    end else begin
      check("rd_en_lockstep", l_rd_en, r_rd_en);
      if (l_rd_en) begin
        pop_count++;
        check("pop_legal", enable && !(out_valid && !out_ready) && l_cnt > 0 && r_cnt > 0, 1);
      end
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {out_left, out_right}, {hold_l, hold_r});
      end
      if (out_valid && out_ready) begin
        $display("frame %0d L=%06h R=%06h", frames_rx, out_left, out_right);
        if (exp_l.size() == 0 || exp_r.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_frame: got L=%06h R=%06h, expected no frame", out_left, out_right);
        end else begin
          check("frame_data", {out_left, out_right}, {exp_l.pop_front(), exp_r.pop_front()});
        end
        frames_rx++;
      end
      hold_prev = out_valid && !out_ready;
      hold_l    = out_left;
      hold_r    = out_right;
      if (underrun) begin
        underrun_seen++;
        check("underrun_single", und_prev, 0);
        check("underrun_streaming", streaming, 0);
      end
      und_prev = underrun;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit do_l, input bit do_r, input logic [DW-1:0] lv, input logic [DW-1:0] rv);
    if (do_l) begin lwr.push_back(lv); exp_l.push_back(lv); end
    if (do_r) begin rwr.push_back(rv); exp_r.push_back(rv); end
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) begin
      push(1, 1, DW'($urandom), DW'($urandom));
      tick();
    end
  endtask

  task automatic wait_frames(input int target, input string name);
    int k = 0;
    while (frames_rx < target && k < 400) begin tick(); k++; end
    if (frames_rx < target) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: frames %0d, expected %0d", name, frames_rx, target);
    end
  endtask

  task automatic wait_underruns(input int target, input string name);
    int k = 0;
    while (underrun_seen < target && k < 400) begin tick(); k++; end
    if (underrun_seen < target) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: underruns %0d, expected %0d", name, underrun_seen, target);
    end
  endtask

  task automatic wait_pop(input string name);
    int k = 0;
    while (!l_rd_en && k < 200) begin tick(); k++; end
    if (!l_rd_en) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: rd_en %0b, expected 1", name, l_rd_en);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_rd_en"}, {l_rd_en, r_rd_en}, 0);
    check({tag, "_underrun"}, underrun, 0);
    check({tag, "_streaming"}, streaming, 0);
    check({tag, "_out_left"}, out_left, 0);
    check({tag, "_out_right"}, out_right, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int bf, bu, bp, seen_run;
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
`ifdef STEREO_FIFO_RD_CTRL_UNDERRUN_CNT_EN
    check("reset_underrun_cnt", underrun_cnt, 0);
`endif
    rst = 1'b0;
    tick();

    // Prefill with the fixed ramp, then drain to the first underrun.
    enable = 1'b1; out_ready = 1'b1;
    bf = frames_rx; bu = underrun_seen; seen_run = 0;
    for (int i = 1; i <= 10; i++) begin
      push(1, 1, DW'(i), DW'(32'h100000 + i));
      tick();
      if (!seen_run) check("no_early_valid", out_valid, 0);
      if (streaming && !seen_run) begin
        seen_run = 1;
        check("prefill_level", l_cnt > AE_LEVEL && r_cnt > AE_LEVEL, 1);
      end
    end
    wait_frames(bf + 10, "p1_frames");
    wait_underruns(bu + 1, "p1_underrun");
    check("p1_frame_count", frames_rx - bf, 10);
    check("p1_underrun_count", underrun_seen - bu, 1);
    check("p1_streaming_after", streaming, 0);

    // Refill five pairs: RUN resumes, nothing lost or duplicated.
    bf = frames_rx; bu = underrun_seen;
    push_rand(5);
    wait_frames(bf + 5, "p2_frames");
    wait_underruns(bu + 1, "p2_underrun");
    check("p2_frame_count", frames_rx - bf, 5);
    check("p2_sb_empty", exp_l.size() + exp_r.size(), 0);

    // Backpressure: one frame pending for 20 cycles, then release.
    bf = frames_rx; bu = underrun_seen;
    out_ready = 1'b0;
    push_rand(8);
    for (int k = 0; k < 50 && !out_valid; k++) tick();
    check("bp_pending", out_valid, 1);
    bp = pop_count;
    repeat (20) tick();
    check("bp_no_pop", pop_count - bp, 0);
    out_ready = 1'b1;
    #1;
    check("bp_release_pop", l_rd_en, 1);
    for (int k = 0; k < RD_LAT; k++) begin
      tick();
      check("bp_gap", out_valid, 0);
    end
    tick();
    check("bp_next_frame", out_valid, 1);
    for (int k = 0; k < 60; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    wait_frames(bf + 8, "p3_frames");
    wait_underruns(bu + 1, "p3_underrun");
    check("p3_frame_count", frames_rx - bf, 8);

    // Asymmetric fill: left only must never pop either side.
    bf = frames_rx; bu = underrun_seen; bp = pop_count;
    for (int i = 0; i < 8; i++) begin push(1, 0, DW'($urandom), '0); tick(); end
    repeat (50) tick();
    check("asym_no_pop", pop_count - bp, 0);
    for (int i = 0; i < 8; i++) begin push(0, 1, '0, DW'($urandom)); tick(); end
    wait_frames(bf + 8, "p4_frames");
    wait_underruns(bu + 1, "p4_underrun");
    check("p4_frame_count", frames_rx - bf, 8);
    check("p4_sb_empty", exp_l.size() + exp_r.size(), 0);

    // Enable drop with a pop in flight: the frame is still delivered once.
    bu = underrun_seen;
    push_rand(8);
    wait_pop("p5_pop");
    tick();
    enable = 1'b0;
    bp = pop_count;
    repeat (10) tick();
    check("drop_no_more_pops", pop_count - bp, 0);
    check("drop_delivered", frames_rx, pop_count);
    check("drop_out_valid", out_valid, 0);
    check("drop_streaming", streaming, 0);
    check("drop_no_underrun", underrun_seen - bu, 0);

    // Reset with a capture outstanding.
    enable = 1'b1;
    push_rand(5);
    wait_pop("p6_pop");
    tick();
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    tick();
    exp_l.delete(); exp_r.delete();
    pop_count = frames_rx;
    rst = 1'b0;
    tick();

    // Three forced underruns.
    bf = frames_rx; bu = underrun_seen;
    for (int u = 0; u < 3; u++) begin
      push_rand(5);
      wait_underruns(bu + u + 1, "p7_underrun");
    end
    check("p7_underrun_count", underrun_seen - bu, 3);
    check("p7_frame_count", frames_rx - bf, 15);
`ifdef STEREO_FIFO_RD_CTRL_UNDERRUN_CNT_EN
    check("cnt_after_three", underrun_cnt, 3);
    enable = 1'b0;
    repeat (3) tick();
    check("cnt_hold_disabled", underrun_cnt, 3);
    enable = 1'b1;
    tick();
    check("cnt_clear_on_rise", underrun_cnt, 0);
`endif
    check("final_sb_empty", exp_l.size() + exp_r.size(), 0);
    check("final_pops_delivered", frames_rx, pop_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stereo_fifo_rd_ctrl.md
Name: stereo_fifo_rd_ctrl

Overview:
- Read-side sequencer for the paired 24-bit Left/Right sample FIFOs (256 deep, distributed, unregistered output).
- Waits for a prefill level, then pops both FIFOs in lockstep so the channels never skew.
- Presents each L/R pair as one stereo frame on a valid/ready output toward the audio/processing sink.
- Detects underrun, then re-prefills.

Parameters:
- DATA_WIDTH, 24, sample width per channel.
- RD_LAT, 1, cycles from rd_en to valid rd_data; legal 1..3.

Ports:
- clk  in  1  single clock; both FIFO read sides run on it.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  streaming enable.
- l_empty  in  1  left FIFO empty.
- l_almost_empty  in  1  left FIFO at or below its almost-empty level.
- l_rd_en  out  1  left FIFO pop.
- l_rd_data  in  DATA_WIDTH  left FIFO read data.
- r_empty, r_almost_empty, r_rd_en, r_rd_data: same as the left-channel ports, for the right FIFO.
- out_valid  out  1  stereo frame valid.
- out_ready  in  1  sink accepts frame.
- out_left  out  DATA_WIDTH  left sample.
- out_right  out  DATA_WIDTH  right sample.
- underrun  out  1  one-cycle pulse on underrun.
- streaming  out  1  high in RUN state.

Behaviour:
- Reset: the controller is in IDLE. out_valid, l_rd_en, r_rd_en, underrun and streaming are 0. out_left and out_right are 0. The in-flight counter is 0.
- IDLE: enable=1 -> PREFILL.
- PREFILL: waits until l_almost_empty=0 and r_almost_empty=0 in the same cycle -> RUN. enable=0 -> IDLE.
- RUN: streaming=1.
  - pop = !inflight && !l_empty && !r_empty && (!out_valid || out_ready) && enable.
  - pop drives l_rd_en and r_rd_en high together for exactly one cycle. The two never differ in any cycle.
- Pop pipeline:
  - A pop in cycle t sets inflight.
  - The block captures l_rd_data/r_rd_data at the clock edge ending cycle t+RD_LAT into out_left/out_right, sets out_valid, and clears inflight.
  - With RD_LAT=1, out_valid is first visible in cycle t+2.
  - At most one pop is in flight at a time.
- Output handshake:
  - The frame is consumed on out_valid && out_ready.
  - out_valid drops the next cycle unless a capture lands on that edge.
  - While out_valid=1 and out_ready=0, out_left, out_right and out_valid hold stable.
  - A pop may issue in the same cycle as a consuming handshake.
- Underrun: in RUN, if out_ready=1, out_valid=0, inflight=0 and (l_empty || r_empty):
  - underrun pulses for 1 cycle.
  - The state goes to PREFILL. No pop is issued.
- Asymmetric empty: if only one FIFO is empty, the controller never pops either FIFO.
- enable falling in RUN:
  - No new pops issue.
  - An in-flight capture completes.
  - A pending frame stays valid until consumed.
  - Then -> IDLE.
  - enable rising again before IDLE is reached has no effect until IDLE is reached.
- rst asserted mid-operation:
  - Everything returns to reset values immediately.
  - An in-flight sample is discarded.
  - The FIFOs are reset by the same signal externally.
- Data is passed through unmodified. No width conversion.

Optional Feature:
- Macro: STEREO_FIFO_RD_CTRL_UNDERRUN_CNT_EN.
- Defined:
  - Adds output underrun_cnt [15:0], a count of underrun pulses.
  - The count saturates at 16'hFFFF.
  - It is cleared by rst and by the rising edge of enable.
- Undefined: the port and counter are absent. Everything else is identical.

Decomposition:
- Shared package stereo_rd_pkg:
  - state enum {IDLE, PREFILL, RUN, DRAIN}; DRAIN is the enable-low flush state.
  - Constant CNT_WIDTH=16.
  - Default DATA_WIDTH=24.
- One sub-module: rd_lat_tracker, a RD_LAT-deep shift of the pop strobe producing the capture strobe and inflight. The FSM stays in the top module.

Test Plan:
- Prefill: 10 samples each, L=0x000001..0x00000A, R=0x100001..0x10000A, almost-empty level 4, out_ready=1, enable=1 -> first out_valid after almost_empty falls. Frames arrive in order (0x000001, 0x100001)…; l_rd_en==r_rd_en every cycle.
- Backpressure: out_ready=0 for 20 cycles with a frame pending -> out_valid and data stable, no rd_en. Release -> next pop in the handshake cycle; the following frame appears at +RD_LAT+1.
- Underrun: after 10 frames, FIFOs empty while out_ready=1 -> underrun single pulse, streaming=0. After refilling 5 each, RUN resumes; no frame is duplicated or lost.
- Asymmetric: left holds 8, right holds 0 -> no rd_en for 50 cycles. Write 8 right samples -> pairs emitted aligned.
- Enable drop with a pop in flight -> the captured frame is delivered once, no further pops, state ends in IDLE.
- Reset mid-capture -> all outputs 0 next cycle. With UNDERRUN_CNT_EN defined: 3 forced underruns give underrun_cnt=3; an enable re-rise gives 0.
